// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the cache refill controller.
//               Holds the controller state encoding and the line geometry
//               (words per line, byte-offset width, word-select width).
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int LINE_WORDS = 16;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;
    // Byte offset within a 64-byte line, and the word index inside it.
    localparam int OFFSET_W   = 6;
    localparam int WORD_SEL_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MEM_REQ = 3'd2,
        FILL    = 3'd3,
        WRITE   = 3'd4,
        RESPOND = 3'd5
    } state_e;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : line_assembler
// Description : Collects memory beats into a full cache line. A beat counter
//               selects which word register captures each beat; clear_i
//               restarts the counter and empties the buffer.
// Ports       : clk_i        - clock, rising edge
//               rst_ni       - asynchronous active-low reset
//               clear_i      - restart assembly (counter and buffer to 0)
//               beat_valid_i - beat_data_i holds the next word of the line
//               beat_data_i  - beat payload
//               line_o       - assembled line, word i at [i*DATA_W +: DATA_W]
//               last_beat_o  - current valid beat completes the line
// Revision    : 1.0 - initial release
// ============================================================================
module line_assembler #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         beat_valid_i,
    input  logic [DATA_W-1:0]            beat_data_i,
    output logic [LINE_WORDS*DATA_W-1:0] line_o,
    output logic                         last_beat_o
);

    localparam int              CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (beat_valid_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_beat_o = beat_valid_i && (cnt_q == LAST_IDX);

    // One register per word with its own enable keeps the write path a
    // simple decoder instead of a full-line read-modify-write mux.
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [DATA_W-1:0] word_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    word_q <= '0;
                end else if (clear_i) begin
                    word_q <= '0;
                end else if (beat_valid_i && (cnt_q == CNT_W'(gi))) begin
                    word_q <= beat_data_i;
                end
            end

            assign line_o[gi*DATA_W +: DATA_W] = word_q;
        end
    endgenerate

endmodule : line_assembler
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Sequences the cache datapath for single outstanding CPU
//               reads: tag lookup, hit return, or a line refill from main
//               memory followed by a cache line write and word return.
// Options     : CACHE_STATS_EN - when defined, adds saturating hit_cnt_o and
//               miss_cnt_o lookup-outcome counters.
// Ports       : clk_i/rst_ni             - clock, async active-low reset
//               cpu_req_i/cpu_addr_i     - read request (sampled in IDLE)
//               cpu_busy_o/cpu_ready_o   - busy level, one-cycle data pulse
//               cpu_rdata_o              - returned word (held until next)
//               cache_addr_o/cache_rd_o  - lookup address and strobe
//               cache_hit_i/valid_i/rdata_i - lookup result, cycle after strobe
//               cache_we_o/cache_wline_o - refill line write
//               mem_req_o/mem_addr_o/mem_ack_i - line fetch handshake
//               mem_rvalid_i/mem_rdata_i - in-order line beats, word 0 first
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cpu_req_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    output logic                         cpu_busy_o,
    output logic                         cpu_ready_o,
    output logic [DATA_W-1:0]            cpu_rdata_o,
    output logic [ADDR_W-1:0]            cache_addr_o,
    output logic                         cache_rd_o,
    input  logic                         cache_hit_i,
    input  logic                         cache_valid_i,
    input  logic [DATA_W-1:0]            cache_rdata_i,
    output logic                         cache_we_o,
    output logic [LINE_WORDS*DATA_W-1:0] cache_wline_o,
    output logic                         mem_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_W-1:0]            mem_rdata_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                  hit_cnt_o,
    output logic [31:0]                  miss_cnt_o
`endif
);

    state_e                         state_q;
    state_e                         state_d;
    logic [ADDR_W-1:0]              addr_q;
    logic [ADDR_W-1:0]              addr_d;
    logic [DATA_W-1:0]              rdata_q;
    logic [DATA_W-1:0]              rdata_d;

    logic                           asm_clear;
    logic                           asm_beat_valid;
    logic                           asm_last_beat;
    logic [LINE_WORDS*DATA_W-1:0]   asm_line;
    logic [WORD_SEL_W-1:0]          word_sel;

    line_assembler #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_assembler (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (asm_clear),
        .beat_valid_i (asm_beat_valid),
        .beat_data_i  (mem_rdata_i),
        .line_o       (asm_line),
        .last_beat_o  (asm_last_beat)
    );

    assign word_sel = addr_q[OFFSET_W-1 -: WORD_SEL_W];

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rdata_d        = rdata_q;
        cache_rd_o     = 1'b0;
        asm_clear      = 1'b0;
        asm_beat_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // The lookup strobe leaves with the request itself so the
                // cache result lands during LOOKUP.
                if (cpu_req_i) begin
                    addr_d     = cpu_addr_i;
                    cache_rd_o = 1'b1;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit_i && cache_valid_i) begin
                    rdata_d = cache_rdata_i;
                    state_d = RESPOND;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_ack_i) begin
                    asm_clear = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                // Beats are only consumed here, so a stray valid in any
                // other state cannot advance the counter.
                if (mem_rvalid_i) begin
                    asm_beat_valid = 1'b1;
                    if (asm_last_beat) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                rdata_d = asm_line[word_sel*DATA_W +: DATA_W];
                state_d = RESPOND;
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // In IDLE the strobe carries the incoming address; otherwise the
    // latched one (also used for the line write).
    assign cache_addr_o  = (state_q == IDLE && cpu_req_i) ? cpu_addr_i : addr_q;
    assign cpu_busy_o    = (state_q != IDLE);
    assign cpu_ready_o   = (state_q == RESPOND);
    assign cpu_rdata_o   = rdata_q;
    assign cache_we_o    = (state_q == WRITE);
    assign cache_wline_o = asm_line;
    assign mem_req_o     = (state_q == MEM_REQ);
    assign mem_addr_o    = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (state_d == RESPOND) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule : cache_refill_ctrl
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cache_refill_ctrl
// Description : Self-checking bench for cache_refill_ctrl. Expected responses
//               are queued when a request is accepted and compared when
//               cpu_ready_o pulses. Stats counters are checked when built
//               with CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 16;

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b0;
    logic                         cpu_req_i = 1'b0;
    logic [ADDR_W-1:0]            cpu_addr_i = '0;
    logic                         cpu_busy_o;
    logic                         cpu_ready_o;
    logic [DATA_W-1:0]            cpu_rdata_o;
    logic [ADDR_W-1:0]            cache_addr_o;
    logic                         cache_rd_o;
    logic                         cache_hit_i = 1'b0;
    logic                         cache_valid_i = 1'b0;
    logic [DATA_W-1:0]            cache_rdata_i = '0;
    logic                         cache_we_o;
    logic [LINE_WORDS*DATA_W-1:0] cache_wline_o;
    logic                         mem_req_o;
    logic [ADDR_W-1:0]            mem_addr_o;
    logic                         mem_ack_i = 1'b0;
    logic                         mem_rvalid_i = 1'b0;
    logic [DATA_W-1:0]            mem_rdata_i = '0;
`ifdef CACHE_STATS_EN
    logic [31:0]                  hit_cnt_o;
    logic [31:0]                  miss_cnt_o;
`endif

    cache_refill_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cpu_req_i     (cpu_req_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_busy_o    (cpu_busy_o),
        .cpu_ready_o   (cpu_ready_o),
        .cpu_rdata_o   (cpu_rdata_o),
        .cache_addr_o  (cache_addr_o),
        .cache_rd_o    (cache_rd_o),
        .cache_hit_i   (cache_hit_i),
        .cache_valid_i (cache_valid_i),
        .cache_rdata_i (cache_rdata_i),
        .cache_we_o    (cache_we_o),
        .cache_wline_o (cache_wline_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests  = 0;
    int n_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc       = 0;
    int          ready_cnt = 0;
    int          we_cnt    = 0;
    int          rd_cnt    = 0;
    int          mreq_cnt  = 0;
    int          bad_words = 0;
    logic [31:0] exp_we_addr = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (cache_rd_o) rd_cnt++;
        if (mem_req_o) mreq_cnt++;
        if (cpu_ready_o) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                check_eq("unexpected_ready", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("rdata", cpu_rdata_o, mon_e.data);
                check_eq("latency", 64'(cyc - mon_e.acc_cyc + 1), 64'(mon_e.lat));
            end
        end
        if (cache_we_o) begin
            we_cnt++;
            bad_words = 0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (cache_wline_o[i*DATA_W +: DATA_W] !== 32'h100 + i) bad_words++;
            end
            check_eq("wline_bad_words", 64'(bad_words), 64'd0);
            check_eq("wline_word2", cache_wline_o[2*DATA_W +: DATA_W], 32'h102);
            check_eq("we_addr", cache_addr_o, exp_we_addr);
        end
    end

    // One CPU read. Miss path plays the memory: ack after d extra MEM_REQ
    // cycles, beats 0x100+i with a gap after each beat whose bit is set in
    // gaps, then a stray beat that must be ignored.
    task automatic do_req(input logic [31:0] a, input logic hit, input logic vld,
                          input logic [31:0] hd, input int d, input logic [15:0] gaps,
                          input int busy_beat, input int rst_beat, input string tag);
        int   rc0, we0, rd0, mq0, acc;
        logic miss;
        miss = !(hit && vld);
        rc0 = ready_cnt; we0 = we_cnt; rd0 = rd_cnt; mq0 = mreq_cnt;
        exp_we_addr   = a;
        cpu_req_i     = 1'b1;
        cpu_addr_i    = a;
        cache_hit_i   = hit;
        cache_valid_i = vld;
        cache_rdata_i = hd;
        @(posedge clk_i); #1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = '0;
        acc        = cyc;
        if (rst_beat < 0) begin
            if (miss) sb.push_back('{32'h100 + {28'h0, a[5:2]}, d + $countones(gaps) + 20, acc});
            else      sb.push_back('{hd, 2, acc});
        end
        if (miss) begin
            @(posedge clk_i); #1;
            check_eq({tag, "_mem_req"}, 64'(mem_req_o), 64'd1);
            check_eq({tag, "_mem_addr"}, mem_addr_o, {a[31:6], 6'h0});
            repeat (d) @(posedge clk_i);
            #1;
            mem_ack_i = 1'b1;
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'h100 + i;
                if (i == busy_beat) begin
                    cpu_req_i  = 1'b1;
                    cpu_addr_i = 32'h40;
                end
                @(posedge clk_i); #1;
                cpu_req_i = 1'b0;
                if (i == busy_beat) check_eq({tag, "_busy"}, 64'(cpu_busy_o), 64'd1);
                if (i == rst_beat) begin
                    mem_rvalid_i = 1'b0;
                    rst_ni = 1'b0;
                    #1;
                    check_eq({tag, "_ctl_outs"},
                             64'({cpu_busy_o, cpu_ready_o, cache_rd_o, cache_we_o, mem_req_o}), 64'd0);
                    check_eq({tag, "_addrs"}, {cache_addr_o, mem_addr_o}, 64'd0);
                    check_eq({tag, "_rdata_wline"}, {cpu_rdata_o, 31'd0, |cache_wline_o}, 64'd0);
                    @(negedge clk_i);
                    rst_ni = 1'b1;
                    @(posedge clk_i); #1;
                    return;
                end
                if (gaps[i]) begin
                    mem_rvalid_i = 1'b0;
                    @(posedge clk_i); #1;
                end
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hBAD;
            @(posedge clk_i); #1;
            mem_rvalid_i = 1'b0;
        end
        for (int k = 0; k < 60 && ready_cnt == rc0; k++) begin
            @(negedge clk_i); #1;
        end
        check_eq({tag, "_ready_cnt"}, 64'(ready_cnt - rc0), 64'd1);
        check_eq({tag, "_we_cnt"}, 64'(we_cnt - we0), miss ? 64'd1 : 64'd0);
        check_eq({tag, "_mreq_cycles"}, 64'(mreq_cnt - mq0), miss ? 64'(d + 1) : 64'd0);
        check_eq({tag, "_lookups"}, 64'(rd_cnt - rd0), 64'd1);
        @(posedge clk_i); #1;
        cache_hit_i   = 1'b0;
        cache_valid_i = 1'b0;
        cache_rdata_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int we_before, rdy_before;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("reset_ctl_outs",
                 64'({cpu_busy_o, cpu_ready_o, cache_rd_o, cache_we_o, mem_req_o}), 64'd0);
        check_eq("reset_rdata_wline", {cpu_rdata_o, 31'd0, |cache_wline_o}, 64'd0);
`ifdef CACHE_STATS_EN
        check_eq("reset_stats", {hit_cnt_o, miss_cnt_o}, 64'd0);
`endif
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        do_req(32'h0000_1044, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 16'h0000, -1, -1, "hit");
        do_req(32'h0000_2088, 1'b0, 1'b0, 32'h0, 3, 16'h0000, -1, -1, "miss");
        do_req(32'h0000_3010, 1'b1, 1'b0, 32'h5555_5555, 1, 16'h4081, -1, -1, "gap");
        do_req(32'h0000_4020, 1'b0, 1'b0, 32'h0, 0, 16'h0000, 4, -1, "busy");

        we_before  = we_cnt;
        rdy_before = ready_cnt;
        do_req(32'h0000_5004, 1'b0, 1'b0, 32'h0, 2, 16'h0000, -1, 5, "rst");
        repeat (6) @(posedge clk_i);
        #1;
        check_eq("rst_no_we", 64'(we_cnt - we_before), 64'd0);
        check_eq("rst_no_ready", 64'(ready_cnt - rdy_before), 64'd0);
        check_eq("rst_idle", 64'(cpu_busy_o), 64'd0);
`ifdef CACHE_STATS_EN
        check_eq("rst_stats", {hit_cnt_o, miss_cnt_o}, 64'd0);
`endif

        do_req(32'h0000_603C, 1'b0, 1'b0, 32'h0, 1, 16'h0100, -1, -1, "post_miss");
        do_req(32'h0000_7000, 1'b1, 1'b1, 32'h1234_5678, 0, 16'h0000, -1, -1, "hit2");
        do_req(32'h0000_7007, 1'b1, 1'b1, 32'hA5A5_0001, 0, 16'h0000, -1, -1, "hit3");
        do_req(32'h0000_8004, 1'b0, 1'b0, 32'h0, 0, 16'h0000, -1, -1, "miss2");
        do_req(32'h0000_9FFC, 1'b1, 1'b1, 32'h0BAD_CAFE, 0, 16'h0000, -1, -1, "hit4");
        check_eq("rdata_held", cpu_rdata_o, 32'h0BAD_CAFE);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

`ifdef CACHE_STATS_EN
        check_eq("stats_hits", hit_cnt_o, 32'd3);
        check_eq("stats_misses", miss_cnt_o, 32'd2);
        rst_ni = 1'b0;
        #2;
        check_eq("stats_after_reset", {hit_cnt_o, miss_cnt_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
`endif

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule : tb_cache_refill_ctrl
`default_nettype wire

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Sequences the cache datapath for CPU read requests.
- Accepts one CPU read at a time and performs a tag lookup in the cache memory.
- On a hit, returns the addressed 32-bit word.
- On a miss, requests the 512-bit line from main memory, assembles it from 32-bit beats, writes it into the cache, then returns the word.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, CPU word / memory beat width.
- LINE_WORDS, 16, words per cache line; line width = LINE_WORDS*DATA_W = 512.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  read request, sampled only in IDLE.
- cpu_addr  in  ADDR_W  byte address, sampled with cpu_req.
- cpu_busy  out  1  high in every state except IDLE.
- cpu_ready  out  1  one-cycle pulse, cpu_rdata valid.
- cpu_rdata  out  DATA_W  returned word.
- cache_addr  out  ADDR_W  latched request address to cache memory.
- cache_rd  out  1  lookup strobe.
- cache_hit  in  1  tag match, valid the cycle after cache_rd.
- cache_valid  in  1  line valid bit, same timing as cache_hit.
- cache_rdata  in  DATA_W  hit word, same timing as cache_hit.
- cache_we  out  1  line write strobe.
- cache_wline  out  LINE_WORDS*DATA_W  refill line; word i at bits [i*32 +: 32].
- mem_req  out  1  line fetch request, held until mem_ack.
- mem_addr  out  ADDR_W  line-aligned address (low 6 bits zero).
- mem_ack  in  1  request accepted.
- mem_rvalid  in  1  beat valid.
- mem_rdata  in  DATA_W  beat data; beats arrive in order, word 0 first.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; line buffer 0.
- IDLE: on cpu_req=1, latch cpu_addr, assert cache_rd for one cycle, go to LOOKUP. cpu_req=0 keeps IDLE.
- LOOKUP: if cache_hit&cache_valid, capture cache_rdata and go to RESPOND. Otherwise go to MEM_REQ.
- MEM_REQ: mem_req=1, mem_addr = {addr[31:6],6'b0}. On mem_ack=1 (same cycle), drop mem_req next cycle and go to FILL with beat counter = 0.
- FILL: each mem_rvalid=1 stores mem_rdata into word[cnt] and increments cnt.
  - On the beat where cnt = LINE_WORDS-1, go to WRITE.
  - Counter width is clog2(LINE_WORDS); it must not wrap into a 17th beat.
  - mem_rvalid=0 cycles stall with no timeout.
- WRITE: cache_we=1 for exactly one cycle with cache_wline = assembled line and cache_addr = latched address. Select word addr[5:2] into the response register, then go to RESPOND.
- RESPOND: cpu_ready=1 and cpu_rdata valid for one cycle, then IDLE. cpu_rdata holds its value until the next RESPOND.
- Latency from the cpu_req accept edge:
  - Hit: cpu_ready on the 2nd cycle after accept (IDLE→LOOKUP→RESPOND).
  - Miss: 2 + ack wait + beat cycles + 1.
- cpu_req while cpu_busy=1 is ignored, never queued.
- mem_ack or mem_rvalid outside MEM_REQ/FILL are ignored.
- cache_hit=1 with cache_valid=0 counts as a miss.
- Reset mid-refill: immediate IDLE, partial line discarded, no cache_we, no cpu_ready.
- Address bits [1:0] are ignored.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds output ports hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - hit_cnt increments on the LOOKUP→RESPOND transition.
  - miss_cnt increments on the LOOKUP→MEM_REQ transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, LOOKUP, MEM_REQ, FILL, WRITE, RESPOND);
  - LINE_WORDS, OFFSET_W=6, WORD_SEL_W=4;
  - line-width localparam.
- One sub-module, line_assembler:
  - beat counter plus indexed 512-bit register;
  - inputs clear, beat_valid, beat_data;
  - outputs line, last_beat.

Test Plan:
- Hit: cpu_addr=32'h0000_1044, cache_hit=1, cache_valid=1, cache_rdata=32'hDEAD_BEEF → cpu_ready exactly 2 cycles after accept with cpu_rdata=32'hDEAD_BEEF; mem_req never asserted.
- Miss refill: addr=32'h0000_2088, mem_ack after 3 cycles, 16 back-to-back beats of value 32'h100+i → mem_addr=32'h0000_2080; one cache_we with word2=32'h102; cpu_rdata=32'h102.
- Gapped beats: insert mem_rvalid=0 after beats 0, 7 and 14 → still exactly 16 beats stored, one cache_we; no extra beat is accepted.
- Busy drop: pulse cpu_req with addr 32'h40 during FILL → ignored, no second lookup; cpu_busy=1 throughout.
- Reset mid-FILL: assert rst_n=0 after beat 5 → all outputs 0 asynchronously; no cache_we after release; a new request proceeds normally.
- With CACHE_STATS_EN: 3 hits and 2 misses → hit_cnt=3, miss_cnt=2; after reset both 0.
